// File: rtl/tlb_cache.sv
// rtl/tlb_cache.sv - fully-associative TLB with one-cycle lookup, fill, invalidate and flush
module tlb_cache #(
    parameter int ENTRIES   = 8,
    parameter int VA_WIDTH  = 32,
    parameter int PA_WIDTH  = 32,
    parameter int PAGE_BITS = 12
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               lookup_valid,
    input  logic [VA_WIDTH-1:0]                lookup_va,
    input  logic                               lookup_store,
    input  logic                               fill_valid,
    input  logic [VA_WIDTH-PAGE_BITS-1:0]      fill_vpn,
    input  logic [PA_WIDTH-PAGE_BITS-1:0]      fill_ppn,
    input  logic                               fill_dirty,
    input  logic                               inval_valid,
    input  logic [VA_WIDTH-PAGE_BITS-1:0]      inval_vpn,
    input  logic                               flush,
    output logic                               resp_valid,
    output logic                               resp_hit,
    output logic [PA_WIDTH-1:0]                resp_pa,
    output logic                               resp_dirty,
    output logic [$clog2(ENTRIES):0]           count,
    output logic                               full
);
    localparam int VPN_W = VA_WIDTH - PAGE_BITS;
    localparam int PPN_W = PA_WIDTH - PAGE_BITS;
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int CNT_W = IDX_W + 1;

    logic [ENTRIES-1:0] valid;
    logic [ENTRIES-1:0] dirty;
    logic [VPN_W-1:0]   tag [ENTRIES];
    logic [PPN_W-1:0]   ppn [ENTRIES];
    logic [IDX_W-1:0]   ptr;

    logic             lk_hit, fl_hit, inv_hit, has_free, evict;
    logic [IDX_W-1:0] lk_idx, fl_idx, inv_idx, free_idx, fill_idx;
    logic [VPN_W-1:0] lk_vpn;

    assign lk_vpn = lookup_va[VA_WIDTH-1:PAGE_BITS];

    // All searches use pre-edge state; the free search runs high-to-low so the lowest index wins.
    always_comb begin
        lk_hit   = 1'b0;
        lk_idx   = '0;
        fl_hit   = 1'b0;
        fl_idx   = '0;
        inv_hit  = 1'b0;
        inv_idx  = '0;
        has_free = 1'b0;
        free_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (valid[i] && tag[i] == lk_vpn) begin
                lk_hit = 1'b1;
                lk_idx = IDX_W'(i);
            end
            if (valid[i] && tag[i] == fill_vpn) begin
                fl_hit = 1'b1;
                fl_idx = IDX_W'(i);
            end
            if (valid[i] && tag[i] == inval_vpn) begin
                inv_hit = 1'b1;
                inv_idx = IDX_W'(i);
            end
            if (!valid[i]) begin
                has_free = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
        evict    = !fl_hit && !has_free;
        fill_idx = fl_hit ? fl_idx : (has_free ? free_idx : ptr);
    end

    // Later assignments override earlier ones, so flush/inval/fill win over the store-hit dirty update.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid      <= '0;
            dirty      <= '0;
            ptr        <= '0;
            resp_valid <= 1'b0;
            resp_hit   <= 1'b0;
            resp_pa    <= '0;
            resp_dirty <= 1'b0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag[i] <= '0;
                ppn[i] <= '0;
            end
        end else begin
            resp_valid <= lookup_valid;
            resp_hit   <= lookup_valid && lk_hit;
            resp_pa    <= (lookup_valid && lk_hit) ?
                          {ppn[lk_idx], lookup_va[PAGE_BITS-1:0]} : '0;
            resp_dirty <= lookup_valid && lk_hit && (dirty[lk_idx] || lookup_store);

            if (lookup_valid && lk_hit && lookup_store)
                dirty[lk_idx] <= 1'b1;

            if (flush) begin
                valid <= '0;
                dirty <= '0;
                ptr   <= '0;
            end else if (inval_valid) begin
                if (inv_hit)
                    valid[inv_idx] <= 1'b0;
            end else if (fill_valid) begin
                valid[fill_idx] <= 1'b1;
                dirty[fill_idx] <= fill_dirty;
                tag[fill_idx]   <= fill_vpn;
                ppn[fill_idx]   <= fill_ppn;
                if (evict)
                    ptr <= ptr + 1'b1;
            end
        end
    end

    always_comb begin
        count = '0;
        for (int i = 0; i < ENTRIES; i++)
            count = count + CNT_W'(valid[i]);
    end

    assign full = (count == CNT_W'(ENTRIES));

endmodule

// File: tb/tb_tlb_cache.sv
// tb/tb_tlb_cache.sv - scoreboard bench for tlb_cache with randomized traffic and a reference model
module tb_tlb_cache;
    localparam int E = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        lookup_valid, lookup_store;
    logic [31:0] lookup_va;
    logic        fill_valid, fill_dirty;
    logic [19:0] fill_vpn, fill_ppn;
    logic        inval_valid;
    logic [19:0] inval_vpn;
    logic        flush;
    logic        resp_valid, resp_hit, resp_dirty;
    logic [31:0] resp_pa;
    logic [2:0]  count;
    logic        full;

    always #5 clk = ~clk;

    tlb_cache #(.ENTRIES(E), .VA_WIDTH(32), .PA_WIDTH(32), .PAGE_BITS(12)) dut (
        .clk(clk), .reset(reset),
        .lookup_valid(lookup_valid), .lookup_va(lookup_va), .lookup_store(lookup_store),
        .fill_valid(fill_valid), .fill_vpn(fill_vpn), .fill_ppn(fill_ppn), .fill_dirty(fill_dirty),
        .inval_valid(inval_valid), .inval_vpn(inval_vpn), .flush(flush),
        .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_pa(resp_pa), .resp_dirty(resp_dirty),
        .count(count), .full(full)
    );

    typedef struct packed {
        logic        hit;
        logic [31:0] pa;
        logic        dirty;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   mon_en  = 0;

    // Reference translation table: a set of slots plus a round-robin eviction counter.
    bit          m_valid [E];
    logic [19:0] m_vpn   [E];
    logic [19:0] m_ppn   [E];
    bit          m_dirty [E];
    int          m_ptr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int m_find(input logic [19:0] vpn);
        for (int i = 0; i < E; i++)
            if (m_valid[i] && m_vpn[i] == vpn) return i;
        return -1;
    endfunction

    task automatic cyc(input bit lv, input logic [31:0] va, input bit st,
                       input bit fv, input logic [19:0] fvpn, input logic [19:0] fppn, input bit fd,
                       input bit iv, input logic [19:0] ivpn, input bit fl, input bit rst);
        exp_t e;
        int   h, k;
        reset = rst; lookup_valid = lv; lookup_va = va; lookup_store = st;
        fill_valid = fv; fill_vpn = fvpn; fill_ppn = fppn; fill_dirty = fd;
        inval_valid = iv; inval_vpn = ivpn; flush = fl;
        h       = m_find(va[31:12]);
        e.hit   = (h >= 0);
        e.pa    = (h >= 0) ? {m_ppn[h], va[11:0]} : 32'h0;
        e.dirty = (h >= 0) && (m_dirty[h] || st);
        @(posedge clk);
        if (lv && !rst) q.push_back(e);
        if (rst) begin
            for (int i = 0; i < E; i++) begin
                m_valid[i] = 0; m_dirty[i] = 0; m_vpn[i] = 0; m_ppn[i] = 0;
            end
            m_ptr = 0;
        end else begin
            if (lv && h >= 0 && st) m_dirty[h] = 1;
            if (fl) begin
                for (int i = 0; i < E; i++) begin
                    m_valid[i] = 0; m_dirty[i] = 0;
                end
                m_ptr = 0;
            end else if (iv) begin
                k = m_find(ivpn);
                if (k >= 0) m_valid[k] = 0;
            end else if (fv) begin
                k = m_find(fvpn);
                if (k < 0)
                    for (int i = E - 1; i >= 0; i--)
                        if (!m_valid[i]) k = i;
                if (k < 0) begin
                    k = m_ptr;
                    m_ptr = (m_ptr + 1) % E;
                end
                m_valid[k] = 1; m_vpn[k] = fvpn; m_ppn[k] = fppn; m_dirty[k] = fd;
            end
        end
        #1;
        begin
            int cnt = 0;
            for (int i = 0; i < E; i++) cnt += m_valid[i];
            chk("count", count, cnt);
            chk("full", full, cnt == E);
        end
    endtask

    task automatic idle();                 cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic do_reset();             cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); endtask
    task automatic look(input logic [31:0] va, input bit st); cyc(1, va, st, 0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic fill(input logic [19:0] v, input logic [19:0] p, input bit d); cyc(0, 0, 0, 1, v, p, d, 0, 0, 0, 0); endtask
    task automatic do_flush();             cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0); endtask

    // Monitor: every negedge, resp_valid must match whether a response is owed.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("resp_valid", resp_valid, q.size() != 0);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    if (resp_valid) begin
                        chk("resp_hit", resp_hit, e.hit);
                        chk("resp_pa", resp_pa, e.pa);
                        chk("resp_dirty", resp_dirty, e.dirty);
                    end
                end
            end
        end
    end

    initial begin
        do_reset();
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_hit", resp_hit, 0);
        chk("rst_resp_pa", resp_pa, 0);
        chk("rst_resp_dirty", resp_dirty, 0);
        mon_en = 1;
        idle();

        // Basic fill then translate
        fill(20'h12345, 20'h00ABC, 0);
        look(32'h12345678, 0);
        idle();

        // Eviction order and pointer wrap
        do_flush();
        for (int v = 1; v <= 5; v++) fill(20'(v), 20'(v + 16'h100), 0);
        look(32'h0000_1000, 0);
        fill(20'h6, 20'h106, 0);
        look(32'h0000_2000, 0);
        look(32'h0000_5abc, 0);
        fill(20'h7, 20'h107, 0);
        fill(20'h8, 20'h108, 0);
        fill(20'h9, 20'h109, 0);
        for (int v = 3; v <= 9; v++) look({20'(v), 12'h010}, 0);

        // Dirty tracking and in-place refill
        do_flush();
        fill(20'h7, 20'h55, 0);
        look(32'h0000_7004, 0);
        look(32'h0000_7008, 1);
        look(32'h0000_700c, 0);
        fill(20'h7, 20'h9, 0);
        look(32'h0000_7123, 0);
        fill(20'h1, 20'h1, 0); fill(20'h2, 20'h2, 0); fill(20'h3, 20'h3, 0);
        fill(20'h4, 20'h4, 0);
        look(32'h0000_7000, 0);
        look(32'h0000_1000, 0);

        // Flush beats fill; same-cycle lookup sees old state
        do_flush();
        fill(20'h7, 20'h77, 1);
        cyc(1, 32'h0000_7abc, 0, 1, 20'h8, 20'h88, 0, 0, 0, 1, 0);
        look(32'h0000_8000, 0);
        look(32'h0000_7000, 0);

        // Inval beats fill; store hit + refill of same entry
        fill(20'h3, 20'h33, 0);
        cyc(0, 0, 0, 1, 20'h4, 20'h44, 0, 1, 20'h3, 0, 0);
        look(32'h0000_3000, 0);
        look(32'h0000_4000, 0);
        fill(20'h5, 20'h55, 0);
        cyc(1, 32'h0000_5000, 1, 1, 20'h5, 20'h66, 0, 0, 0, 0, 0);
        look(32'h0000_5000, 0);

        // Reset discards pending lookup and clears table
        fill(20'h2, 20'h22, 1);
        look(32'h0000_2000, 0);
        cyc(1, 32'h0000_2000, 1, 1, 20'h9, 20'h9, 0, 0, 0, 0, 1);
        look(32'h0000_2000, 0);
        look(32'h0000_9000, 0);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            bit          lv, st, fv, iv, fl, rs;
            logic [31:0] va;
            lv = ($urandom_range(0, 99) < 60);
            st = $urandom_range(0, 1);
            fv = ($urandom_range(0, 99) < 40);
            iv = ($urandom_range(0, 99) < 10);
            fl = ($urandom_range(0, 99) < 3);
            rs = ($urandom_range(0, 99) < 1);
            va = {20'($urandom_range(0, 6)), 12'($urandom)};
            cyc(lv, va, st, fv, 20'($urandom_range(0, 6)), 20'($urandom), 1'($urandom),
                iv, 20'($urandom_range(0, 6)), fl, rs);
        end
        idle();
        idle();
        chk("scoreboard_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tlb_cache.md
TLB_CACHE -- requirements
Module: tlb_cache

Interface
REQ-001 Parameter ENTRIES, default 8, number of fully-associative entries; power of two, >= 2.
REQ-002 Parameter VA_WIDTH, default 32, virtual address width.
REQ-003 Parameter PA_WIDTH, default 32, physical address width.
REQ-004 Parameter PAGE_BITS, default 12, page offset width; VPN width = VA_WIDTH-PAGE_BITS, PPN width = PA_WIDTH-PAGE_BITS.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 lookup_valid  in  1  lookup request this cycle.
REQ-008 lookup_va  in  VA_WIDTH  virtual address to translate.
REQ-009 lookup_store  in  1  lookup is a store access; marks entry dirty on hit.
REQ-010 fill_valid  in  1  install translation.
REQ-011 fill_vpn  in  VPN width  virtual page number to install.
REQ-012 fill_ppn  in  PPN width  physical page number to install.
REQ-013 fill_dirty  in  1  initial dirty bit of installed entry.
REQ-014 inval_valid  in  1  invalidate entry matching inval_vpn.
REQ-015 inval_vpn  in  VPN width  page number to invalidate.
REQ-016 flush  in  1  invalidate all entries.
REQ-017 resp_valid  out  1  response for lookup of previous cycle.
REQ-018 resp_hit  out  1  translation found.
REQ-019 resp_pa  out  PA_WIDTH  {ppn, page offset} on hit, 0 on miss.
REQ-020 resp_dirty  out  1  entry dirty bit after this access; 0 on miss.
REQ-021 count  out  log2(ENTRIES)+1  number of valid entries.
REQ-022 full  out  1  count == ENTRIES.

Function
REQ-023 Lookup latency SHALL be 1 cycle: lookup_valid at edge N -> resp_valid=1 with resp_hit/resp_pa/resp_dirty held registered for cycle N+1; resp_valid=0 in cycles following no lookup.
REQ-024 Lookup SHALL compare against entry state prior to edge N (fill/inval/flush in the same cycle not visible).
REQ-025 At most one valid entry per VPN at any time; match is valid && tag==lookup_va[VA_WIDTH-1:PAGE_BITS].
REQ-026 Store hit SHALL set that entry's dirty bit at edge N and report resp_dirty=1; load hit reports stored dirty bit unchanged.
REQ-027 Miss SHALL give resp_hit=0, resp_pa=0, resp_dirty=0; no state change.
REQ-028 Fill placement: VPN already valid -> overwrite that entry in place (ppn, dirty); else lowest-index invalid entry; else entry at victim pointer (eviction).
REQ-029 Victim pointer SHALL advance by 1 modulo ENTRIES only on eviction; wraps ENTRIES-1 -> 0.
REQ-030 inval_valid SHALL clear valid of the matching entry; no match -> no effect; pointer unchanged.
REQ-031 flush SHALL clear all valid and dirty bits and set pointer to 0 at the edge.
REQ-032 Priority in one cycle: flush > inval_valid > fill_valid; a lower-priority operation in the same cycle is dropped entirely.
REQ-033 Fill to the entry receiving a store-hit dirty update in the same cycle: fill values win.
REQ-034 count/full SHALL reflect post-edge state and update in the same edge as the causing operation.

Reset
REQ-035 On reset at an edge: all entries invalid, dirty and tags 0, pointer 0, resp_valid/resp_hit/resp_dirty 0, resp_pa 0, count 0, full 0.
REQ-036 Reset mid-operation SHALL discard any pending response and all requests presented in that cycle; reset overrides all inputs.

Verification (ENTRIES=4, PAGE_BITS=12)
REQ-037 Fill vpn 0x12345->ppn 0x00ABC; next cycle lookup 0x12345678 -> one cycle later resp_hit=1, resp_pa=0x00ABC678, resp_dirty=0, count=1.
REQ-038 Fill vpns 1,2,3,4 then 5 -> vpn1 evicted (lookup 0x00001000 misses, resp_pa=0), full=1; fill 6 evicts vpn2; pointer wraps after four evictions.
REQ-039 Load lookup then store lookup on filled vpn 0x7 -> resp_dirty 0 then 1; subsequent load reports 1.
REQ-040 Refill existing vpn 0x7 with ppn 0x9 -> count unchanged, lookup returns ppn 0x9, pointer unchanged.
REQ-041 Same cycle flush + fill vpn 0x8 + lookup of valid vpn 0x7 -> response hits (old state), afterwards count=0 and vpn 0x8 misses.
REQ-042 Reset asserted in cycle after lookup_valid -> resp_valid=0, count=0, all later lookups miss.
